// File: rtl/fma_normalize_if.sv
`default_nettype none
// ============================================================================
// Module   : fma_normalize_if
// Brief    : Upstream/downstream handshake bundle for the FMA normalizer.
// Revision : 1.0
// ============================================================================
interface fma_normalize_if #(
  parameter int SUMW = 158,
  parameter int MANW = 53,
  parameter int EXPW = 13
);
  logic            in_valid;
  logic            in_ready;
  logic [SUMW-1:0] in_sum;
  logic [EXPW-1:0] in_exp;
  logic            in_sign;

  logic            out_valid;
  logic            out_ready;
  logic [MANW-1:0] out_mant;
  logic            out_guard;
  logic            out_sticky;
  logic [EXPW-1:0] out_exp;
  logic            out_sign;
  logic            out_zero;

  modport slave (
    input  in_valid, in_sum, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_guard, out_sticky,
           out_exp, out_sign, out_zero
  );

  modport master (
    output in_valid, in_sum, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_guard, out_sticky,
           out_exp, out_sign, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/fma_normalize.sv
`default_nettype none
// ============================================================================
// Module   : fma_normalize
// Brief    : Two-stage post-add normalizer (leading-zero count, then shift).
//            Define FMA_NORM_STATS_EN to add cancellation/zero counters.
// Revision : 1.0
// ============================================================================
module fma_normalize #(
  parameter int SUMW = 158,
  parameter int MANW = 53,
  parameter int EXPW = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  fma_normalize_if.slave       bus
`ifdef FMA_NORM_STATS_EN
  ,
  output logic [31:0]          stat_cancel,
  output logic [31:0]          stat_zero
`endif
);

  localparam int LZW = $clog2(SUMW + 1);

  logic            s2_free;
  logic            s1_adv;
  logic            in_ready_w;
  logic            accept;
  logic [LZW-1:0]  lzc_w;
  logic [SUMW-1:0] shifted_w;

  logic            s1_valid_q, s1_valid_d;
  logic [SUMW-1:0] s1_sum_q,   s1_sum_d;
  logic [EXPW-1:0] s1_exp_q,   s1_exp_d;
  logic            s1_sign_q,  s1_sign_d;
  logic            s1_zero_q,  s1_zero_d;
  logic [LZW-1:0]  s1_lzc_q,   s1_lzc_d;

  logic            s2_valid_q,  s2_valid_d;
  logic [MANW-1:0] out_mant_q,  out_mant_d;
  logic            out_guard_q, out_guard_d;
  logic            out_sticky_q, out_sticky_d;
  logic [EXPW-1:0] out_exp_q,   out_exp_d;
  logic            out_sign_q,  out_sign_d;
  logic            out_zero_q,  out_zero_d;

  always_comb begin
    s2_free    = ~s2_valid_q | bus.out_ready;
    s1_adv     = s1_valid_q & s2_free;
    in_ready_w = (~s1_valid_q | s1_adv) & ~flush;
    accept     = bus.in_valid & in_ready_w;
  end

  // Lowest-to-highest scan: the last hit is the most significant set bit.
  always_comb begin
    lzc_w = LZW'(SUMW);
    for (int i = 0; i < SUMW; i++) begin
      if (bus.in_sum[i]) begin
        lzc_w = LZW'(SUMW - 1 - i);
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_lzc_d   = s1_lzc_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = bus.in_sum;
      s1_exp_d   = bus.in_exp;
      s1_sign_d  = bus.in_sign;
      s1_zero_d  = (bus.in_sum == '0);
      s1_lzc_d   = lzc_w;
    end
    if (flush) begin
      s1_valid_d = 1'b0;
    end
  end

  assign shifted_w = s1_sum_q << s1_lzc_q;

  always_comb begin
    s2_valid_d   = s2_valid_q;
    out_mant_d   = out_mant_q;
    out_guard_d  = out_guard_q;
    out_sticky_d = out_sticky_q;
    out_exp_d    = out_exp_q;
    out_sign_d   = out_sign_q;
    out_zero_d   = out_zero_q;
    if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      out_sign_d = s1_sign_q;
      if (s1_zero_q) begin
        out_mant_d   = '0;
        out_guard_d  = 1'b0;
        out_sticky_d = 1'b0;
        out_exp_d    = '0;
        out_zero_d   = 1'b1;
      end else begin
        out_mant_d   = shifted_w[SUMW-1 -: MANW];
        out_guard_d  = shifted_w[SUMW-MANW-1];
        out_sticky_d = |shifted_w[SUMW-MANW-2:0];
        // Wraps modulo 2^EXPW; range handling belongs to the rounder.
        out_exp_d    = s1_exp_q - EXPW'(s1_lzc_q);
        out_zero_d   = 1'b0;
      end
    end
    if (flush) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_exp_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_lzc_q     <= '0;
      s2_valid_q   <= 1'b0;
      out_mant_q   <= '0;
      out_guard_q  <= 1'b0;
      out_sticky_q <= 1'b0;
      out_exp_q    <= '0;
      out_sign_q   <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sum_q     <= s1_sum_d;
      s1_exp_q     <= s1_exp_d;
      s1_sign_q    <= s1_sign_d;
      s1_zero_q    <= s1_zero_d;
      s1_lzc_q     <= s1_lzc_d;
      s2_valid_q   <= s2_valid_d;
      out_mant_q   <= out_mant_d;
      out_guard_q  <= out_guard_d;
      out_sticky_q <= out_sticky_d;
      out_exp_q    <= out_exp_d;
      out_sign_q   <= out_sign_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_guard  = out_guard_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_sign   = out_sign_q;
  assign bus.out_zero   = out_zero_q;

`ifdef FMA_NORM_STATS_EN
  logic        delivered;
  logic        s2_cancel_q, s2_cancel_d;
  logic [31:0] stat_cancel_q, stat_cancel_d;
  logic [31:0] stat_zero_q,   stat_zero_d;

  always_comb begin
    delivered     = s2_valid_q & bus.out_ready;
    s2_cancel_d   = s1_adv ? (s1_lzc_q > LZW'(MANW)) : s2_cancel_q;
    stat_cancel_d = stat_cancel_q;
    stat_zero_d   = stat_zero_q;
    // Flush still counts a result that handshakes in the same cycle.
    if (delivered && s2_cancel_q) begin
      stat_cancel_d = stat_cancel_q + 32'd1;
    end
    if (delivered && out_zero_q) begin
      stat_zero_d = stat_zero_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_cancel_q   <= 1'b0;
      stat_cancel_q <= '0;
      stat_zero_q   <= '0;
    end else begin
      s2_cancel_q   <= s2_cancel_d;
      stat_cancel_q <= stat_cancel_d;
      stat_zero_q   <= stat_zero_d;
    end
  end

  assign stat_cancel = stat_cancel_q;
  assign stat_zero   = stat_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fma_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma_normalize
// Brief    : Scoreboard bench for fma_normalize (optional FMA_NORM_STATS_EN).
// Revision : 1.0
// ============================================================================
module tb_fma_normalize;

  typedef struct {
    logic [52:0] mant;
    logic        g;
    logic        s;
    logic [12:0] e;
    logic        sign;
    logic        zero;
    int          lz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   lat_en = 1'b0;
  exp_t sb[$];

  fma_normalize_if #(.SUMW(158), .MANW(53), .EXPW(13)) bus ();

`ifdef FMA_NORM_STATS_EN
  logic [31:0] stat_cancel, stat_zero;
  int unsigned mdl_cancel = 0, mdl_zero = 0;
`endif

  fma_normalize #(.SUMW(158), .MANW(53), .EXPW(13)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef FMA_NORM_STATS_EN
    ,
    .stat_cancel (stat_cancel),
    .stat_zero   (stat_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [157:0] s, input logic [12:0] e, input logic sg);
    exp_t r;
    logic [157:0] sh;
    int lz;
    lz = 158;
    for (int i = 157; i >= 0; i--) begin
      if (s[i]) begin
        lz = 157 - i;
        break;
      end
    end
    sh = s << lz;
    r.sign = sg;
    r.lz = lz;
    r.cyc = cyc;
    if (lz == 158) begin
      r.mant = '0; r.g = 1'b0; r.s = 1'b0; r.e = '0; r.zero = 1'b1;
    end else begin
      r.mant = sh[157:105]; r.g = sh[104]; r.s = |sh[103:0];
      r.e = e - 13'(lz); r.zero = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [69:0] pk(input exp_t r);
    return {r.mant, r.g, r.s, r.e, r.sign, r.zero};
  endfunction

  function automatic logic [69:0] dut_pk();
    return {bus.out_mant, bus.out_guard, bus.out_sticky, bus.out_exp, bus.out_sign, bus.out_zero};
  endfunction

  // Queue holds exactly the beats in flight; flush/reset kill all of them.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
`ifdef FMA_NORM_STATS_EN
      mdl_cancel = 0;
      mdl_zero = 0;
`endif
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 160'(dut_pk()), 160'd0);
        end else if (bus.out_ready) begin
          check("out", 160'(dut_pk()), 160'(pk(sb[0])));
          if (lat_en) check("latency", 160'(cyc - sb[0].cyc), 160'd2);
`ifdef FMA_NORM_STATS_EN
          if (sb[0].lz > 53) mdl_cancel++;
          if (sb[0].zero) mdl_zero++;
`endif
          void'(sb.pop_front());
        end else begin
          check("hold", 160'(dut_pk()), 160'(pk(sb[0])));
        end
      end
      if (flush) sb.delete();
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_sum, bus.in_exp, bus.in_sign));
    end
  end

  task automatic send(input logic [157:0] s, input logic [12:0] e, input logic sg);
    bus.in_valid = 1'b1;
    bus.in_sum = s;
    bus.in_exp = e;
    bus.in_sign = sg;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 160'd1, 160'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [52:0] m, input logic g, input logic s,
                            input logic [12:0] e, input logic sg, input logic z);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check(tag, 160'(dut_pk()), 160'({m, g, s, e, sg, z}));
        return;
      end
    end
    check({tag, "_timeout"}, 160'd0, 160'd1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    check("drain_timeout", 160'(sb.size()), 160'd0);
  endtask

  function automatic logic [157:0] rnd_sum();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) return '0;
    return t[157:0] >> $urandom_range(0, 157);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    bus.in_valid = 1'b0;
    bus.in_sum = '0;
    bus.in_exp = '0;
    bus.in_sign = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 160'(bus.out_valid), 160'd0);
    check("rst_outputs", 160'(dut_pk()), 160'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 160'(bus.in_ready), 160'd1);

    // Known-answer cases, unstalled.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    lat_en = 1'b1;
    send(158'd1 << 157, 13'd100, 1'b0);
    expect_out("kat_top", 53'd1 << 52, 1'b0, 1'b0, 13'd100, 1'b0, 1'b0);
    send(158'h7, 13'd0, 1'b0);
    expect_out("kat_low", 53'h7 << 50, 1'b0, 1'b0, 13'h1F65, 1'b0, 1'b0);
    send((158'd1 << 157) | (158'd1 << 104) | 158'd1, 13'd50, 1'b1);
    expect_out("kat_gs", 53'd1 << 52, 1'b1, 1'b1, 13'd50, 1'b1, 1'b0);
    send(158'd0, 13'h123, 1'b1);
    expect_out("kat_zero", 53'd0, 1'b0, 1'b0, 13'd0, 1'b1, 1'b1);
    drain();
    lat_en = 1'b0;

    // Five-beat stream with a four-cycle downstream stall.
    @(posedge clk); #1;
    fork
      begin
        for (int n = 0; n < 5; n++) send(158'h3 << (20 * n + 7), 13'(n * 11), n[0]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall_in_ready", 160'(bus.in_ready), 160'd0);
        check("stall_depth", 160'(sb.size()), 160'd2);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both stages full and a third beat waiting.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(158'd1 << 150, 13'd10, 1'b0);
    send(158'd1 << 90, 13'd20, 1'b1);
    fork
      send(158'd5 << 40, 13'd30, 1'b0);
      begin
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 160'(bus.in_ready), 160'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 160'(bus.out_valid), 160'd0);
        check("flush_in_ready_after", 160'(bus.in_ready), 160'd1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of traffic also clears data registers.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(158'd9 << 100, 13'd77, 1'b1);
    send(158'd3 << 60, 13'd66, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 160'(bus.out_valid), 160'd0);
    check("rst_mid_outputs", 160'(dut_pk()), 160'd0);
    check("rst_mid_in_ready", 160'(bus.in_ready), 160'd1);

    // Random stream with random backpressure.
    @(posedge clk); #1;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) send(rnd_sum(), 13'($urandom()), 1'($urandom()));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);

`ifdef FMA_NORM_STATS_EN
    @(negedge clk);
    check("stat_cancel", 160'(stat_cancel), 160'(mdl_cancel));
    check("stat_zero", 160'(stat_zero), 160'(mdl_zero));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fma_normalize.md
Name: fma_normalize

Overview:
- Post-add normalization stage of the FMA datapath.
- Consumes the 158-bit magnitude sum from the compound-adder stage. That sum is already sign-corrected through its negsum/inversion muxing.
- Locates the leading one, left-shifts it to the top, and produces a 53-bit significand with guard/sticky plus an adjusted exponent for the rounder.
- Two-stage pipeline with valid/ready handshakes on both sides and a synchronous flush.

Parameters:
- SUMW, 158, width of incoming sum.
- MANW, 53, output significand width including the integer bit.
- EXPW, 13, signed exponent width, two's complement.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_sum  input  SUMW  unsigned magnitude from the adder stage.
- in_exp  input  EXPW  exponent corresponding to bit SUMW-1 of in_sum.
- in_sign  input  1  result sign, passed through.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_mant  output  MANW  normalized significand; MSB = 1 unless out_zero.
- out_guard  output  1  first bit below out_mant.
- out_sticky  output  1  OR of all remaining lower bits.
- out_exp  output  EXPW  adjusted exponent.
- out_sign  output  1  sign.
- out_zero  output  1  in_sum was all zeros.

Behaviour:
- Clocking: single clock clk; reset synchronous, active-high.
- Reset: s1_valid = s2_valid = 0. All output registers clear to 0 (out_valid, out_mant, out_guard, out_sticky, out_exp, out_sign, out_zero).
- Stage 1 (LZC), on accept:
  - Register lzc = number of leading zeros of in_sum, range 0..SUMW. lzc = SUMW means zero.
  - Register in_sum, in_exp, in_sign, zero = (in_sum == 0).
- Stage 2 (shift), on advance:
  - shifted = s1_sum << lzc, SUMW bits.
  - out_mant = shifted[SUMW-1 : SUMW-MANW].
  - out_guard = shifted[SUMW-MANW-1].
  - out_sticky = |shifted[SUMW-MANW-2 : 0].
  - out_exp = s1_exp - lzc, modulo 2^EXPW with no saturation; the rounder handles range.
  - out_sign = s1_sign.
- Zero case: out_mant = 0, out_guard = 0, out_sticky = 0, out_exp = 0, out_zero = 1; sign passes through unchanged.
- Handshake:
  - s2_free = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = (~s1_valid | s1_adv) & ~flush.
  - Input accepted when in_valid & in_ready.
  - out_valid = s2_valid.
- Latency and throughput:
  - Latency 2 cycles from accept to out_valid when unstalled.
  - Throughput 1 beat per cycle.
  - No bubbles inserted while out_ready stays high.
- Stall: while out_valid & ~out_ready, all out_* stay bit-stable. Stage 1 holds if full; in_ready drops once both stages are full.
- Simultaneous drain and fill: a stage may be emptied and refilled in the same cycle, with no lost or duplicated beats.
- Flush:
  - Next edge clears s1_valid and s2_valid.
  - A beat presented in the flush cycle is not accepted (in_ready = 0).
  - Data registers need not clear.
  - flush overrides out_ready; a result handshaken in the flush cycle counts as delivered.
- Reset mid-operation: same as flush, and data registers also clear to 0. Reset overrides flush.
- in_valid may rise without waiting for in_ready. Once asserted, the upstream holds in_valid and its data until accepted.

Optional Feature:
- Macro: FMA_NORM_STATS_EN.
- Defined:
  - Adds output port stat_cancel, 32 bits. It counts delivered results with lzc > MANW, i.e. massive cancellation.
  - Adds output port stat_zero, 32 bits. It counts delivered zero results.
  - Counters increment on out_valid & out_ready and wrap at 2^32.
  - Both clear on reset only; flush does not clear them.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- in_sum = 1<<157, in_exp = 100, out_ready = 1 -> two cycles later: out_mant = 1<<52, guard = 0, sticky = 0, out_exp = 100, out_zero = 0.
- in_sum = 0x7 (bits 2:0), in_exp = 0 -> lzc = 155: out_mant = 0b111<<50, guard = 0, sticky = 0, out_exp = -155 (13'h1F65).
- in_sum = (1<<157)|(1<<104)|1 -> out_mant = 1<<52, guard = 1, sticky = 1, out_exp = in_exp.
- in_sum = 0, in_sign = 1 -> out_zero = 1, out_mant = 0, out_exp = 0, out_sign = 1.
- Stream of 5 beats, out_ready low for cycles 3-6 -> in_ready drops after 2 beats are held. Outputs stay stable during the stall. All 5 results emerge in order, no duplicates or losses.
- Pipeline full, assert flush for 1 cycle -> next cycle out_valid = 0 and in_ready = 1. No stale beat ever appears. With FMA_NORM_STATS_EN, the counters are unchanged by the flushed beats.
